gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Sequencer that walks a programmable binary index range (up or down, modular wrap) and streams the Gray-coded value of each index on a valid/ready output. It owns one instance of the team's existing combinational bin2gray converter and drives its binary input from a registered counter. Sits between a config/start source and any Gray-consuming sink, such as an encoder model or a test pattern port.

Parameters:
WIDTH, 4, bit width of the index, the binary value and the Gray value; must be ≥2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  sampled only in IDLE; launches a sequence
abort  in  1  terminates the current sequence
cfg_first  in  WIDTH  first binary index; captured when start is accepted
cfg_last  in  WIDTH  last binary index; captured when start is accepted
cfg_dir  in  1  0 = increment, 1 = decrement; captured at start
cfg_cont  in  1  0 = single-shot, 1 = continuous (repeat until abort); captured at start
out_valid  out  1  out_gray, out_bin and out_last hold a beat
out_ready  in  1  sink accepts the beat
out_gray  out  WIDTH  Gray code of out_bin, from the bin2gray instance
out_bin  out  WIDTH  current binary index (registered)
out_last  out  1  current beat equals the captured last index
busy  out  1  high in RUN
done  out  1  one-cycle pulse when a single-shot sequence completes

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE; cnt, first_q, last_q = 0; dir_q, cont_q = 0.
  - Outputs under reset: out_valid=0, busy=0, done=0, out_last=0, out_bin=0, out_gray=0.
- States:
  - IDLE:
    - start=1 and abort=0 → capture the cfg_* inputs, cnt←cfg_first, go to RUN.
    - start=1 and abort=1 in the same cycle → stay in IDLE (abort wins).
  - RUN:
    - out_valid=1 and busy=1.
    - Handshake = out_valid & out_ready.
      - On a handshake with cnt≠last_q: cnt←cnt+1 (dir 0) or cnt−1 (dir 1), modulo 2^WIDTH.
      - On a handshake with cnt==last_q:
        - cont_q=1 → cnt←first_q, stay in RUN.
        - cont_q=0 → go to DONE.
  - DONE: done=1, out_valid=0, busy=0; IDLE on the next cycle unconditionally. start is ignored in DONE.
- Latency:
  - start accepted at edge N → out_valid=1 with out_bin=cfg_first from cycle N+1.
  - Each handshake advances the beat by exactly one cycle, so the throughput is 1 beat/cycle while out_ready=1.
- Output stability:
  - While out_valid=1 and out_ready=0, out_bin, out_gray and out_last hold their values.
  - out_gray is purely combinational from registered cnt, through bin2gray.
- out_last = (state==RUN) & (cnt==last_q).
- Beat count per pass:
  - Up: ((last−first) mod 2^WIDTH) + 1.
  - Down: ((first−last) mod 2^WIDTH) + 1.
  - first==last → 1 beat, with out_last high on it.
- Wrap-around: up 2^WIDTH−1 → 0; down 0 → 2^WIDTH−1. No error is flagged.
- abort in RUN → next state IDLE; out_valid drops next cycle; done is not pulsed. If a handshake occurs in the abort cycle, the beat counts as delivered.
- Handshake on the last beat in the same cycle as abort, with cont=0: abort wins, so the next state is IDLE and done is not pulsed.
- start while in RUN or DONE: ignored; the captured config stays unchanged.
- cfg_* changes outside the start-accept cycle have no effect.
- rst_n low mid-sequence → immediate return to reset values, with no done pulse.

Decomposition:
- Package gray_seq_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - dir_t enum {DIR_UP=0, DIR_DOWN=1}
  - localparam DEFAULT_WIDTH=4
- Sub-module: the existing bin2gray instance. Its binary input is cnt and its gray output is out_gray. No other sub-module; next-count logic stays inline.

Test Plan:
1. Single-shot up, WIDTH=4, first=3, last=6, dir=0, cont=0, out_ready=1 → out_gray 0010, 0110, 0111, 0101 on cycles N+1..N+4; out_last only on the 4th beat; done pulse at N+5; IDLE at N+6.
2. Up wrap, first=14, last=1 → out_bin 14, 15, 0, 1; out_gray 1001, 1000, 0000, 0001; exactly 4 beats, then done.
3. Down, first=2, last=0, dir=1 with out_ready low for 3 cycles on beat 2 → out_bin holds at 1 (gray 0001) for those cycles; full sequence 0011, 0001, 0000; busy stays high throughout; single done pulse.
4. Continuous, first=5, last=5, cont=1, ready=1 → out_bin=5 (gray 0111) every cycle with out_last=1; abort after 6 beats → out_valid=0 next cycle, no done; a start in that same cycle is ignored.
5. start while busy, first=0, last=7, with a second start carrying first=9 at beat 3 → sequence is 0..7 unaffected; start+abort together in IDLE → stays IDLE, out_valid=0.
6. rst_n pulsed low at beat 2 of a 0→15 sequence → all outputs 0 asynchronously; after release, a new start with first=8, last=8 yields one beat, gray 1100, and a done pulse.

Source files
------------

// File: rtl/gray_seq_pkg.sv
// rtl/gray_seq_pkg.sv - shared types and defaults for the Gray-code sequencer
package gray_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/bin2gray.sv
// rtl/bin2gray.sv - combinational binary to reflected Gray code converter
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - walks a binary index range and streams its Gray code
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_first,
    input  logic [WIDTH-1:0] cfg_last,
    input  logic             cfg_dir,
    input  logic             cfg_cont,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] first_q;
    logic [WIDTH-1:0] last_q;
    dir_t             dir_q;
    logic             cont_q;
    logic             load;
    logic             hs;
    logic             at_last;

    assign hs      = (state == RUN) && out_ready;
    assign at_last = (cnt == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            first_q <= '0;
            last_q  <= '0;
            dir_q   <= DIR_UP;
            cont_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                first_q <= cfg_first;
                last_q  <= cfg_last;
                dir_q   <= dir_t'(cfg_dir);
                cont_q  <= cfg_cont;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = RUN;
                    cnt_nx   = cfg_first;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    if (at_last) begin
                        if (cont_q) begin
                            cnt_nx = first_q;
                        end else begin
                            state_nx = DONE;
                        end
                    end else if (dir_q == DIR_DOWN) begin
                        cnt_nx = cnt - ONE;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                // abort overrides completion even when the last beat is taken
                if (abort) begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign out_last  = (state == RUN) && at_last;
    assign out_bin   = cnt;

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (cnt),
        .gray (out_gray)
    );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - self-checking bench for gray_seq_ctrl
module tb_gray_seq_ctrl;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] cfg_first = '0;
    logic [W-1:0] cfg_last = '0;
    logic         cfg_dir = 1'b0;
    logic         cfg_cont = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_gray;
    logic [W-1:0] out_bin;
    logic         out_last;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int gtab[M];

    typedef struct {
        int f;
        int l;
        bit dir;
        bit cont;
        bit noisy;
        int pct;
        int stall;
        int abrt;
        int exp_beats;
        int exp_g0;
        int exp_gl;
        bit exp_done;
    } vec_t;

    vec_t tbl[9];

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .cfg_dir   (cfg_dir),
        .cfg_cont  (cfg_cont),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input bit en);
        if (en) begin
            start     = 1'($urandom);
            cfg_first = W'($urandom);
            cfg_last  = W'($urandom);
            cfg_dir   = 1'($urandom);
            cfg_cont  = 1'($urandom);
        end else begin
            start = 1'b0;
        end
    endtask

    // Reference: the expected index list of one pass, by modular arithmetic.
    task automatic fill(input int f, input int l, input bit dir, output int q[$]);
        int n;
        q = {};
        n = dir ? (((f - l) % M + M) % M) + 1 : (((l - f) % M + M) % M) + 1;
        for (int k = 0; k < n; k++)
            q.push_back(dir ? ((f - k) % M + M) % M : (f + k) % M);
    endtask

    task automatic run_seq(input int f, input int l, input bit dir, input bit cont,
                           input bit noisy, input int pct, input int stall_beat,
                           input int abort_after, output int beats, output int g_first,
                           output int g_last, output bit done_seen);
        int  q[$];
        int  budget;
        int  stall;
        bit  hs;
        bit  aborting;
        beats = 0; g_first = -1; g_last = -1; done_seen = 1'b0;
        stall = 0; budget = 0;
        fill(f, l, dir, q);
        cfg_first = W'(f); cfg_last = W'(l); cfg_dir = dir; cfg_cont = cont;
        start = 1'b1; abort = 1'b0; out_ready = 1'b0;
        step();
        while (1) begin
            budget++;
            if (budget > 3000) begin
                checks++; errors++;
                $display("FAIL budget: sequence did not finish, got %0d beats", beats);
                start = 1'b0;
                return;
            end
            if (q.size() == 0) begin
                if (cont) fill(f, l, dir, q);
                else break;
            end
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("done_in_run", done, 0);
            chk("bin", out_bin, q[0]);
            chk("gray", out_gray, gtab[q[0]]);
            chk("last", out_last, int'(q.size() == 1));
            if (g_first < 0) g_first = out_gray;
            if (stall_beat == beats && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ($urandom_range(0, 99) < pct);
            end
            aborting = (abort_after >= 0 && beats == abort_after);
            abort = aborting;
            noise(noisy);
            if (aborting) start = 1'b1;
            hs = out_ready;
            step();
            if (hs) begin
                g_last = gtab[q[0]];
                beats++;
                void'(q.pop_front());
            end
            if (aborting) begin
                abort = 1'b0; start = 1'b0; out_ready = 1'b0;
                chk("abort_valid", out_valid, 0);
                chk("abort_done", done, 0);
                chk("abort_busy", busy, 0);
                step();
                chk("abort_idle_valid", out_valid, 0);
                chk("abort_idle_done", done, 0);
                return;
            end
        end
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_last", out_last, 0);
        done_seen = done;
        noise(noisy);
        step();
        start = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int beats, g0, gl;
        bit dn;

        // Gray table by the reflect-and-prefix construction.
        gtab[0] = 0;
        for (int k = 0; k < W; k++)
            for (int i = 0; i < (1 << k); i++)
                gtab[(1 << k) + i] = (1 << k) | gtab[(1 << k) - 1 - i];

        //              f   l  dir cont noisy pct stall abrt beats g0 gl done
        tbl[0] = '{ 3,  6, 1'b0, 1'b0, 1'b0, 100, -1, -1,  4,  2,  5, 1'b1};
        tbl[1] = '{14,  1, 1'b0, 1'b0, 1'b0, 100, -1, -1,  4,  9,  1, 1'b1};
        tbl[2] = '{ 2,  0, 1'b1, 1'b0, 1'b0, 100,  1, -1,  3,  3,  0, 1'b1};
        tbl[3] = '{ 5,  5, 1'b0, 1'b1, 1'b0, 100, -1,  6,  7,  7,  7, 1'b0};
        tbl[4] = '{ 0,  7, 1'b0, 1'b0, 1'b1, 100, -1, -1,  8,  0,  4, 1'b1};
        tbl[5] = '{ 0,  2, 1'b0, 1'b0, 1'b0, 100, -1,  2,  3,  0,  3, 1'b0};
        tbl[6] = '{15,  0, 1'b1, 1'b0, 1'b0, 100, -1, -1, 16,  8,  0, 1'b1};
        tbl[7] = '{ 1,  0, 1'b0, 1'b0, 1'b0,  60, -1, -1, 16,  1,  0, 1'b1};
        tbl[8] = '{ 0,  1, 1'b1, 1'b0, 1'b1,  70, -1, -1, 16,  0,  1, 1'b1};

        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_bin", out_bin, 0);
        chk("rst_gray", out_gray, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            run_seq(tbl[i].f, tbl[i].l, tbl[i].dir, tbl[i].cont, tbl[i].noisy, tbl[i].pct,
                    tbl[i].stall, tbl[i].abrt, beats, g0, gl, dn);
            chk($sformatf("row%0d_beats", i), beats, tbl[i].exp_beats);
            chk($sformatf("row%0d_gray_first", i), g0, tbl[i].exp_g0);
            chk($sformatf("row%0d_gray_last", i), gl, tbl[i].exp_gl);
            chk($sformatf("row%0d_done", i), int'(dn), int'(tbl[i].exp_done));
        end

        // start together with abort in IDLE is refused
        cfg_first = 4'd3; cfg_last = 4'd9; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_valid", out_valid, 0);
        chk("start_abort_busy", busy, 0);
        step();
        chk("start_abort_valid2", out_valid, 0);

        // asynchronous reset in the middle of a 0..15 walk
        cfg_first = 4'd0; cfg_last = 4'd15; cfg_dir = 1'b0; cfg_cont = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre_rst_bin", out_bin, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_bin", out_bin, 0);
        chk("arst_gray", out_gray, 0);
        chk("arst_last", out_last, 0);
        out_ready = 1'b0;
        step();
        chk("arst_hold_done", done, 0);
        rst_n = 1'b1;
        step();
        run_seq(8, 8, 1'b0, 1'b0, 1'b0, 100, -1, -1, beats, g0, gl, dn);
        chk("post_rst_beats", beats, 1);
        chk("post_rst_gray", g0, 12);
        chk("post_rst_done", int'(dn), 1);

        // randomized passes against the reference model
        for (int it = 0; it < 40; it++) begin
            int f, l, n, ab, pct;
            bit dir, cont, exp_done;
            f = $urandom_range(0, M - 1);
            l = $urandom_range(0, M - 1);
            dir = 1'($urandom);
            cont = ($urandom_range(0, 3) == 0);
            pct = $urandom_range(30, 100);
            n = dir ? (((f - l) % M + M) % M) + 1 : (((l - f) % M + M) % M) + 1;
            if (cont) ab = $urandom_range(0, 20);
            else ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
            exp_done = !cont && !(ab >= 0 && ab < n);
            run_seq(f, l, dir, cont, 1'b1, pct, -1, ab, beats, g0, gl, dn);
            chk("rand_done", int'(dn), int'(exp_done));
            if (exp_done) chk("rand_beats", beats, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
